// File: rtl/bcd_pkg.sv
// Shared constants for the BCD up/down counter.
//   DIGIT_W   : width of one packed BCD digit
//   SEG_0..9  : active-low 7-segment patterns, bit 7 is dp (held off)
//   SEG_BLANK : all segments off
package bcd_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h98;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/bcd_updown_counter_seg7_dec.sv
// seg7_dec: combinational BCD digit to active-low 7-segment decoder.
//   digit : 4-bit BCD digit (0..9)
//   seg   : active-low segment pattern, bit 7 = dp (always 1)
module seg7_dec
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: multi-digit BCD up/down counter stepped by a prescaler,
// with wrap/saturate at the terminal value and 7-segment display outputs.
//   CLK1     : clock, all state changes on rising edge
//   RST_N    : asynchronous active-low reset
//   EN       : prescaler advance enable
//   UP       : 1 = count up, 0 = count down
//   WRAP     : 1 = wrap at terminal value, 0 = saturate
//   CLR      : synchronous clear (highest priority)
//   LOAD     : synchronous load of LOAD_VAL (digits > 9 stored as 9)
//   LOAD_VAL : packed BCD load value, digit 0 in [3:0]
//   BCD      : packed registered count
//   HEX      : per-digit active-low 7-segment pattern, digit d in [8d+7:8d]
//   TC       : one-cycle pulse following a terminal-count tick
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int   DIGITS   = 6,
   parameter int   TICK_DIV = 50_000_000,
   parameter logic BLANK_LZ = 1'b1
) (
   input  logic                        CLK1,
   input  logic                        RST_N,
   input  logic                        EN,
   input  logic                        UP,
   input  logic                        WRAP,
   input  logic                        CLR,
   input  logic                        LOAD,
   input  logic [DIGIT_W*DIGITS-1:0]   LOAD_VAL,
   output logic [DIGIT_W*DIGITS-1:0]   BCD,
   output logic [8*DIGITS-1:0]         HEX,
   output logic                        TC
);

   localparam int            PW        = $clog2(TICK_DIV + 1);
   localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

   logic [PW-1:0]               presc;
   logic                        tick;
   logic [DIGITS:0]             carry;
   logic                        terminal;
   logic [DIGIT_W*DIGITS-1:0]   step_val;
   logic [DIGIT_W*DIGITS-1:0]   load_clamped;

   assign tick = EN && (presc == PRESC_TOP);

   always_ff @(posedge CLK1 or negedge RST_N) begin
      if (!RST_N) begin
         presc <= '0;
      end else if (CLR || LOAD) begin
         presc <= '0;
      end else if (EN) begin
         presc <= tick ? '0 : presc + PW'(1);
      end
   end

   // carry[d] means digit d must step this tick; carry[DIGITS] therefore
   // flags that every digit sits at the terminal value for the direction.
   assign carry[0] = 1'b1;
   assign terminal = carry[DIGITS];

   for (genvar d = 0; d < DIGITS; d++) begin : gen_digit
      logic [3:0] cur;
      logic [3:0] nxt;
      logic [3:0] ld;
      logic [7:0] seg;

      assign cur = BCD[DIGIT_W*d +: DIGIT_W];
      assign carry[d+1] = carry[d] & (UP ? (cur == 4'd9) : (cur == 4'd0));

      always_comb begin
         nxt = cur;
         if (carry[d]) begin
            if (UP) nxt = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
            else    nxt = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
         end
      end

      assign step_val[DIGIT_W*d +: DIGIT_W] = nxt;

      assign ld = LOAD_VAL[DIGIT_W*d +: DIGIT_W];
      assign load_clamped[DIGIT_W*d +: DIGIT_W] = (ld > 4'd9) ? 4'd9 : ld;

      seg7_dec u_seg (
         .digit (cur),
         .seg   (seg)
      );

      // Digit 0 always shows; higher digits blank when they and everything
      // above them are zero.
      if (d == 0) begin : gen_lsd
         assign HEX[8*d +: 8] = seg;
      end else begin : gen_hsd
         assign HEX[8*d +: 8] =
            (BLANK_LZ && (BCD[DIGIT_W*DIGITS-1:DIGIT_W*d] == '0)) ? SEG_BLANK : seg;
      end
   end

   always_ff @(posedge CLK1 or negedge RST_N) begin
      if (!RST_N) begin
         BCD <= '0;
      end else if (CLR) begin
         BCD <= '0;
      end else if (LOAD) begin
         BCD <= load_clamped;
      end else if (tick && !(terminal && !WRAP)) begin
         BCD <= step_val;
      end
   end

   always_ff @(posedge CLK1 or negedge RST_N) begin
      if (!RST_N) TC <= 1'b0;
      else        TC <= tick && terminal && !CLR && !LOAD;
   end

endmodule
